// File: rtl/p_accumulator.sv
// p_accumulator: 48-bit add/sub ALU feeding the P register of the DSP slice.
// Latency: 1 cycle with PREG=1 (P/CARRYOUT registered), 0 cycles with PREG=0.
// No backpressure: CEP freezes P, CARRYOUT and the detect history; RSTP clears regardless of CEP.
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   RSTP, CEP        synchronous clear / clock enable for P, CARRYOUT, det_past
//   X, C             48-bit operands; X_SEL gates X, Z_SEL picks 0 / P / C / P>>>17
//   SUB, CARRYIN     0: Z + X + CARRYIN ; 1: Z - (X + CARRYIN)
//   PATTERNDETECT    registered match flag for the current P (drives autoreset)
//   P, CARRYOUT      48-bit result and bit 48 of the 49-bit sum
module p_accumulator #(
  parameter int PREG             = 1,
  parameter int AUTORESET_PATDET = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic [47:0] X,
  input  logic [47:0] C,
  input  logic        X_SEL,
  input  logic [1:0]  Z_SEL,
  input  logic        SUB,
  input  logic        CARRYIN,
  input  logic        PATTERNDETECT,
  output logic [47:0] P,
  output logic        CARRYOUT
);

  localparam bit HAS_PREG = (PREG != 0);

  // Out-of-range autoreset modes behave as NO_RESET.
  localparam int AR_MODE = (AUTORESET_PATDET == 1 || AUTORESET_PATDET == 2) ?
                           AUTORESET_PATDET : 0;

  logic [47:0] p_q;
  logic        co_q;
  logic        det_past;
  logic [47:0] p_shr;
  logic [47:0] xop;
  logic [47:0] zop;
  logic [48:0] r;
  logic        ar;

  assign p_shr = $signed(p_q) >>> 17;

  always_comb begin
    xop = '0;
    if (X_SEL) begin
      xop = X;
    end
  end

  // P feedback is only meaningful when P is registered; without PREG the
  // feedback selections read zero so no combinational loop is formed.
  always_comb begin
    zop = '0;
    case (Z_SEL)
      2'b01:   zop = HAS_PREG ? p_q   : '0;
      2'b10:   zop = C;
      2'b11:   zop = HAS_PREG ? p_shr : '0;
      default: zop = '0;
    endcase
  end

  // Subtraction is Z + ~X + ~CARRYIN over 48 bits, so bit 48 of the result is
  // a "no borrow" flag: 1 when Z >= X + CARRYIN.
  always_comb begin
    if (SUB) begin
      r = {1'b0, zop} + {1'b0, ~xop} + {48'd0, ~CARRYIN};
    end else begin
      r = {1'b0, zop} + {1'b0, xop} + {48'd0, CARRYIN};
    end
  end

  always_comb begin
    ar = 1'b0;
    case (AR_MODE)
      1:       ar = PATTERNDETECT;
      2:       ar = det_past & ~PATTERNDETECT;  // match just lost
      default: ar = 1'b0;
    endcase
  end

  // With PREG=0 the registers are held at zero and never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= '0;
      co_q     <= 1'b0;
      det_past <= 1'b0;
    end else if (!HAS_PREG || RSTP) begin
      p_q      <= '0;
      co_q     <= 1'b0;
      det_past <= 1'b0;
    end else if (CEP) begin
      det_past <= PATTERNDETECT;
      if (ar) begin
        p_q  <= '0;
        co_q <= 1'b0;
      end else begin
        p_q  <= r[47:0];
        co_q <= r[48];
      end
    end
  end

  assign P        = HAS_PREG ? p_q  : r[47:0];
  assign CARRYOUT = HAS_PREG ? co_q : r[48];

endmodule

// File: tb/tb_p_accumulator.sv
// Bench for p_accumulator: directed table, autoreset sequences, random vs model.
// Four instances share operands: PREG=1 with modes 0/1/2 and PREG=0 (mode 0).
// Mode 1 is paired with a small pattern detector (PATTERN=3, no mask) modelled here.
module tb_p_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rstp, cep, x_sel, sub, cin;
  logic [1:0]  z_sel;
  logic [47:0] x, c;
  logic        pd0, pd1, pd2;
  logic [47:0] p0, p1, p2, pc;
  logic        co0, co1, co2, coc;

  int vectors = 0;
  int miscompares = 0;

  // Reference state of the PREG=1 / mode 0 instance.
  logic [47:0] mp;
  logic        mco;

  p_accumulator #(.PREG(1), .AUTORESET_PATDET(0)) u0 (
    .clk(clk), .rst_n(rst_n), .RSTP(rstp), .CEP(cep), .X(x), .C(c), .X_SEL(x_sel),
    .Z_SEL(z_sel), .SUB(sub), .CARRYIN(cin), .PATTERNDETECT(pd0), .P(p0), .CARRYOUT(co0));
  p_accumulator #(.PREG(1), .AUTORESET_PATDET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .RSTP(rstp), .CEP(cep), .X(x), .C(c), .X_SEL(x_sel),
    .Z_SEL(z_sel), .SUB(sub), .CARRYIN(cin), .PATTERNDETECT(pd1), .P(p1), .CARRYOUT(co1));
  p_accumulator #(.PREG(1), .AUTORESET_PATDET(2)) u2 (
    .clk(clk), .rst_n(rst_n), .RSTP(rstp), .CEP(cep), .X(x), .C(c), .X_SEL(x_sel),
    .Z_SEL(z_sel), .SUB(sub), .CARRYIN(cin), .PATTERNDETECT(pd2), .P(p2), .CARRYOUT(co2));
  p_accumulator #(.PREG(0), .AUTORESET_PATDET(0)) uc (
    .clk(clk), .rst_n(rst_n), .RSTP(rstp), .CEP(cep), .X(x), .C(c), .X_SEL(x_sel),
    .Z_SEL(z_sel), .SUB(sub), .CARRYIN(cin), .PATTERNDETECT(pd0), .P(pc), .CARRYOUT(coc));

  // Pattern detector for u1: registered "P == 3", shares CEP/RSTP with P.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pd1 <= 1'b0;
    else if (rstp) pd1 <= 1'b0;
    else if (cep)  pd1 <= (p1 == 48'd3);
  end

  // Plain-arithmetic result: {CARRYOUT, P}. Subtract reports "no borrow" in bit 48.
  function automatic logic [48:0] ref_alu(input logic [47:0] z, input logic [47:0] xo,
                                          input logic s, input logic ci);
    logic [63:0] zz, xx, d;
    zz = {16'd0, z};
    xx = {16'd0, xo};
    if (!s) begin
      d = zz + xx + 64'(ci);
      return d[48:0];
    end
    if (zz >= xx + 64'(ci)) begin
      d = zz - xx - 64'(ci);
      return {1'b1, d[47:0]};
    end
    d = zz + 64'h0001_0000_0000_0000 - xx - 64'(ci);
    return {1'b0, d[47:0]};
  endfunction

  function automatic logic [47:0] ref_z(input logic [1:0] zs, input logic [47:0] pv,
                                        input logic [47:0] cv, input logic fb);
    case (zs)
      2'd1:    return fb ? pv : 48'd0;
      2'd2:    return cv;
      2'd3:    return fb ? 48'($signed(pv) >>> 17) : 48'd0;
      default: return 48'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven at the negedge; the combinational instance is checked
  // before the edge, the registered mode 0 instance just after it.
  task automatic tick();
    logic [48:0] rc;
    #1;
    rc = ref_alu(ref_z(z_sel, mp, c, 1'b0), x_sel ? x : 48'd0, sub, cin);
    chk("comb", {15'd0, coc, pc}, {15'd0, rc});
    @(posedge clk);
    if (!rst_n || rstp) begin
      mp  = '0;
      mco = 1'b0;
    end else if (cep) begin
      {mco, mp} = ref_alu(ref_z(z_sel, mp, c, 1'b1), x_sel ? x : 48'd0, sub, cin);
    end
    #1;
    chk("mode0", {15'd0, co0, p0}, {15'd0, mco, mp});
    @(negedge clk);
  endtask

  typedef struct {
    logic        rs, ce, xs;
    logic [1:0]  zs;
    logic        sb, ci;
    logic [47:0] xv, cv, ep;
    logic        eco;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic ce, input logic xs, input logic [1:0] zs,
                              input logic sb, input logic ci, input logic [47:0] xv,
                              input logic [47:0] cv, input logic [47:0] ep, input logic eco);
    vec_t v;
    v.rs = rs; v.ce = ce; v.xs = xs; v.zs = zs; v.sb = sb; v.ci = ci;
    v.xv = xv; v.cv = cv; v.ep = ep; v.eco = eco;
    return v;
  endfunction

  vec_t tbl[15];

  int m1_cep[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
  int m1_exp[13] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 4, 4, 0, 1};

  int m2_pd[12]   = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};
  int m2_cep[12]  = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  int m2_rstp[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int m2_exp[12]  = '{1, 2, 3, 0, 1, 2, 2, 0, 1, 2, 0, 1};

  initial begin
    //            rs ce xs zs     sb ci X                   C                   expected P          CO
    tbl[0]  = mk(0, 1, 1, 2'b10, 0, 1, 48'd5,              48'd7,              48'd13,             1'b0);
    tbl[1]  = mk(0, 1, 1, 2'b10, 0, 0, 48'hFFFF_FFFF_FFFF, 48'd1,              48'd0,              1'b1);
    tbl[2]  = mk(0, 1, 1, 2'b10, 1, 0, 48'd5,              48'd3,              48'hFFFF_FFFF_FFFE, 1'b0);
    tbl[3]  = mk(0, 1, 1, 2'b10, 1, 0, 48'd3,              48'd5,              48'd2,              1'b1);
    tbl[4]  = mk(0, 1, 0, 2'b00, 0, 0, 48'd0,              48'd0,              48'd0,              1'b0);
    tbl[5]  = mk(0, 1, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd1,              1'b0);
    tbl[6]  = mk(0, 1, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd2,              1'b0);
    tbl[7]  = mk(0, 1, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd3,              1'b0);
    tbl[8]  = mk(0, 1, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd4,              1'b0);
    tbl[9]  = mk(0, 0, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd4,              1'b0);
    tbl[10] = mk(0, 0, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd4,              1'b0);
    tbl[11] = mk(1, 0, 1, 2'b01, 0, 0, 48'd1,              48'd0,              48'd0,              1'b0);
    tbl[12] = mk(0, 1, 0, 2'b10, 0, 0, 48'd0,              48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0);
    tbl[13] = mk(0, 1, 0, 2'b11, 0, 0, 48'd0,              48'd0,              48'hFFFF_C000_0000, 1'b0);
    tbl[14] = mk(1, 1, 1, 2'b01, 0, 0, 48'd9,              48'd0,              48'd0,              1'b0);

    rst_n = 1'b0; rstp = 1'b0; cep = 1'b0; x_sel = 1'b0; sub = 1'b0; cin = 1'b0;
    z_sel = 2'b00; x = '0; c = '0; pd0 = 1'b0; pd2 = 1'b0;
    mp = '0; mco = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", {14'd0, co0 | co1 | co2, p0 | p1 | p2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the mode 0 instance.
    for (int i = 0; i < 15; i++) begin
      rstp = tbl[i].rs; cep = tbl[i].ce; x_sel = tbl[i].xs; z_sel = tbl[i].zs;
      sub = tbl[i].sb; cin = tbl[i].ci; x = tbl[i].xv; c = tbl[i].cv;
      tick();
      chk($sformatf("tbl%0d", i), {15'd0, co0, p0}, {15'd0, tbl[i].eco, tbl[i].ep});
    end
    rstp = 1'b0;

    // Asynchronous reset mid-accumulation, then restart from zero.
    cep = 1'b1; x_sel = 1'b0; z_sel = 2'b10; sub = 1'b0; cin = 1'b0; c = 48'd100;
    tick();
    rst_n = 1'b0;
    #2;
    chk("async_rst", {16'd0, p0 | p1 | p2}, 64'd0);
    mp = '0; mco = 1'b0;
    tick();
    rst_n = 1'b1;
    x_sel = 1'b1; x = 48'd1; z_sel = 2'b01;
    tick();
    chk("after_rst", {16'd0, p0}, 64'd1);

    // AUTORESET mode 1: clear two edges after P reaches the pattern.
    rstp = 1'b1; cep = 1'b1;
    tick();
    rstp = 1'b0; x_sel = 1'b1; x = 48'd1; z_sel = 2'b01; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cep = m1_cep[i][0];
      tick();
      chk($sformatf("ar1_%0d", i), {16'd0, p1}, 64'(m1_exp[i]));
    end

    // AUTORESET mode 2: clear when a held match is lost.
    rstp = 1'b1; cep = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      pd2 = m2_pd[i][0]; cep = m2_cep[i][0]; rstp = m2_rstp[i][0];
      tick();
      chk($sformatf("ar2_%0d", i), {16'd0, p2}, 64'(m2_exp[i]));
    end
    rstp = 1'b0;

    // Random stimulus against the reference model.
    for (int i = 0; i < 400; i++) begin
      rstp  = ($urandom_range(0, 15) == 0);
      cep   = ($urandom_range(0, 3) != 0);
      x_sel = 1'($urandom_range(0, 1));
      z_sel = 2'($urandom_range(0, 3));
      sub   = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
      x     = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), $urandom};
      c     = {16'($urandom), $urandom};
      pd0   = 1'($urandom_range(0, 1));
      pd2   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
